bit_demux_deserializer: RTL and testbench
=========================================

Name: bit_demux_deserializer

Overview:
Inverse of the 8:1 bit-select path. Takes a 1-bit serial stream under a valid/ready handshake and routes each bit into the 8-bit word position given by an internal 3-bit index counter, which acts as a 1-to-8 demux select. It presents each completed byte on a valid/ready output port. It sits between bit-serial sources, such as a serial debug or load channel, and the byte-wide datapath.

Parameters:
MSB_FIRST, 0, 0: first accepted bit goes to out_word[0] and the index counts up 0..7. 1: first bit goes to out_word[7] and the position counts down 7..0.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous abort of a partially assembled word
in_valid  input  1  in_bit is valid this cycle
in_bit  input  1  serial data bit
in_ready  output  1  block can accept in_bit this cycle
out_valid  output  1  out_word holds a complete byte
out_ready  input  1  consumer accepts out_word this cycle
out_word  output  8  assembled byte (registered)
bit_index  output  3  count of bits already accepted into the current word (0..7)

Behaviour:
- States: COLLECT and HOLD.
- Accept event: in_valid && in_ready at a rising edge.
- Transfer event: out_valid && out_ready at a rising edge.
- Reset (reset=1 at an edge, in any state, overrides everything): state=COLLECT, bit_index=0, assembly register=0, out_word=0, out_valid=0. Any partial or held word is discarded.
- in_ready is combinational from state and out_ready: 1 in COLLECT; 1 in HOLD only when out_ready=1; 0 otherwise. It does not depend on in_valid.
- Write position p: p = bit_index when MSB_FIRST=0; p = 7 - bit_index when MSB_FIRST=1. On accept, the assembly register at position p gets in_bit, and all other positions hold.
- COLLECT, accept with bit_index<7: write bit, bit_index+1. No output change.
- COLLECT, accept with bit_index==7:
  - out_word gets the assembly register with position p replaced by in_bit. This is a single-cycle latency: the byte is visible the cycle after the 8th accept.
  - out_valid becomes 1, state goes to HOLD.
  - bit_index wraps to 0 and the assembly register clears to 0.
- HOLD: out_word and out_valid are stable until a transfer.
  - Transfer without accept: out_valid becomes 0, state goes to COLLECT.
  - Transfer with simultaneous accept: the byte is consumed and the new bit is written at index 0 (position per MSB_FIRST) of the cleared assembly register. bit_index becomes 1, out_valid becomes 0, state goes to COLLECT. This gives zero-bubble back-to-back streaming.
- flush (reset has priority over flush):
  - In COLLECT: bit_index becomes 0 and the assembly register becomes 0. A same-cycle in_bit is dropped, but in_ready still reads 1, so the source considers the bit consumed.
  - In HOLD: a held out_word/out_valid is not affected. Only the (already empty) assembly state is cleared. If a transfer and accept coincide with flush, the transfer completes and the accepted bit is dropped (bit_index=0).
- Unwritten positions of a partial word read 0 internally. A partial word is never visible on out_word.
- in_bit is ignored whenever in_valid=0 or in_ready=0. out_ready is ignored when out_valid=0.
- No combinational path from in_bit or in_valid to out_word or out_valid.

Test Plan:
- Reset, then MSB_FIRST=0; feed bits 1,0,1,1,0,0,1,0 on consecutive cycles with out_ready=0 -> the cycle after the 8th bit: out_valid=1, out_word=8'h4D, in_ready=0, bit_index=0. Holds for 5 idle cycles.
- MSB_FIRST=1 with the same stream 1,0,1,1,0,0,1,0 -> out_word=8'hB2.
- Back-to-back: stream 16 bits continuously (8'hA5 then 8'h3C, LSB first) with out_ready=1 throughout -> in_ready never drops. out_valid pulses one cycle with 8'hA5, and again exactly 8 cycles later with 8'h3C.
- Backpressure: complete 8'hFF, hold out_ready=0 for 3 cycles while in_valid=1 with in_bit=0 -> no bits accepted and out_word stays 8'hFF. Raise out_ready with in_bit=1 -> transfer occurs, next cycle bit_index=1, and the next byte's bit 0 is 1.
- Flush: accept 3 bits 1,1,1, assert flush for 1 cycle, then send 8'h01 LSB first -> out_word=8'h01, with no residue from the flushed bits.
- Mid-operation reset: accept 5 bits, or sit in HOLD with 8'h77, then assert reset 1 cycle -> out_valid=0, out_word=8'h00, bit_index=0, in_ready=1. The next full byte 8'h5A assembles correctly.

Source files
------------

// File: rtl/bit_demux_deserializer.sv
// Serial-to-byte deserializer: a 3-bit index acts as a 1-to-8 demux select into an
// assembly register; completed bytes are presented on a registered valid/ready port.
module bit_demux_deserializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_word,
  output logic [2:0] bit_index
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] asm_reg;
  logic [7:0] asm_wr;
  logic [2:0] pos;
  logic       accept;
  logic       transfer;

  assign in_ready = (state == COLLECT) || ((state == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;
  assign transfer = out_valid && out_ready;
  assign pos      = MSB_FIRST ? (3'd7 - bit_index) : bit_index;

  // Assembly register with the incoming bit merged at the current position; used both
  // for ordinary writes and to form the completed byte on the 8th accept.
  always_comb begin
    asm_wr      = asm_reg;
    asm_wr[pos] = in_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= COLLECT;
      bit_index <= '0;
      asm_reg   <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (flush) begin
            bit_index <= '0;
            asm_reg   <= '0;
          end else if (accept) begin
            if (bit_index == 3'd7) begin
              out_word  <= asm_wr;
              out_valid <= 1'b1;
              state     <= HOLD;
              bit_index <= '0;
              asm_reg   <= '0;
            end else begin
              asm_reg   <= asm_wr;
              bit_index <= bit_index + 3'd1;
            end
          end
        end
        HOLD: begin
          // Assembly state is already empty here, so asm_wr is the new bit alone.
          if (transfer) begin
            out_valid <= 1'b0;
            state     <= COLLECT;
          end
          if (accept && !flush) begin
            asm_reg   <= asm_wr;
            bit_index <= 3'd1;
          end else begin
            asm_reg   <= '0;
            bit_index <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_demux_deserializer.sv
// Directed bench for bit_demux_deserializer: table-driven vectors plus hand-written
// multi-cycle sequences; an MSB-first instance shares the stimulus.
module tb_bit_demux_deserializer;

  logic       clk = 1'b0;
  logic       reset, flush, in_valid, in_bit, out_ready;
  logic       in_ready, out_valid, in_ready1, out_valid1;
  logic [7:0] out_word, out_word1;
  logic [2:0] bit_index, bit_index1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  bit_demux_deserializer #(.MSB_FIRST(1'b0)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .bit_index(bit_index)
  );

  bit_demux_deserializer #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_word(out_word1), .bit_index(bit_index1)
  );

  typedef struct {
    logic       rst, fl, iv, ib, ordy;
    logic       e_ir, e_ov, chk_w;
    logic [7:0] e_w;
    logic [2:0] e_bi;
  } vec_t;

  vec_t tv[$];

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, fl, iv, ib, ordy, e_ir, e_ov, chk_w,
                     input logic [7:0] e_w, input logic [2:0] e_bi);
    vec_t v;
    v = '{rst, fl, iv, ib, ordy, e_ir, e_ov, chk_w, e_w, e_bi};
    tv.push_back(v);
  endtask

  task automatic drive(input logic rst, fl, iv, ib, ordy);
    reset = rst; flush = fl; in_valid = iv; in_bit = ib; out_ready = ordy;
  endtask

  // Inputs change just after a falling edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ordy);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 1'b1, b[i], ordy);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_state(input string tag, input logic e_ir, e_ov,
                             input logic [7:0] e_w, input logic [2:0] e_bi);
    #1;
    chk({tag, " in_ready"}, {7'd0, in_ready}, {7'd0, e_ir});
    chk({tag, " out_valid"}, {7'd0, out_valid}, {7'd0, e_ov});
    chk({tag, " bit_index"}, {5'd0, bit_index}, {5'd0, e_bi});
    chk({tag, " out_word"}, out_word, e_w);
    chk({tag, " out_word_msb"}, out_word1, rev8(e_w));
  endtask

  logic [7:0] b2b [2];
  logic [15:0] stream;

  initial begin
    // rst fl iv ib ordy | ir ov chkw word bi
    add(0,0,0,0,0, 1,0,1,8'h00,3'd0);
    add(0,0,1,1,0, 1,0,1,8'h00,3'd0);
    add(0,0,1,0,0, 1,0,1,8'h00,3'd1);
    add(0,0,1,1,0, 1,0,1,8'h00,3'd2);
    add(0,0,1,1,0, 1,0,1,8'h00,3'd3);
    add(0,0,1,0,0, 1,0,1,8'h00,3'd4);
    add(0,0,1,0,0, 1,0,1,8'h00,3'd5);
    add(0,0,1,1,0, 1,0,1,8'h00,3'd6);
    add(0,0,1,0,0, 1,0,1,8'h00,3'd7);
    for (int i = 0; i < 5; i++) add(0,0,0,0,0, 0,1,1,8'h4D,3'd0);
    add(0,0,0,0,1, 1,1,1,8'h4D,3'd0);
    add(0,0,0,0,0, 1,0,0,8'h00,3'd0);
    add(0,0,1,1,0, 1,0,0,8'h00,3'd0);
    add(0,0,1,1,0, 1,0,0,8'h00,3'd1);
    add(0,0,1,1,0, 1,0,0,8'h00,3'd2);
    add(0,1,1,1,0, 1,0,0,8'h00,3'd3);
    add(0,0,1,1,0, 1,0,0,8'h00,3'd0);
    for (int i = 1; i < 8; i++) add(0,0,1,0,0, 1,0,0,8'h00,3'(i));
    add(0,0,0,0,0, 0,1,1,8'h01,3'd0);
    add(0,0,0,0,1, 1,1,1,8'h01,3'd0);
    add(0,0,0,0,0, 1,0,0,8'h00,3'd0);
    for (int i = 0; i < 5; i++) add(0,0,1,1,0, 1,0,0,8'h00,3'(i));
    add(1,0,0,0,0, 1,0,0,8'h00,3'd5);
    add(0,0,0,0,0, 1,0,1,8'h00,3'd0);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    step();

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].fl, tv[i].iv, tv[i].ib, tv[i].ordy);
      #1;
      chk($sformatf("vec%0d in_ready", i), {7'd0, in_ready}, {7'd0, tv[i].e_ir});
      chk($sformatf("vec%0d out_valid", i), {7'd0, out_valid}, {7'd0, tv[i].e_ov});
      chk($sformatf("vec%0d bit_index", i), {5'd0, bit_index}, {5'd0, tv[i].e_bi});
      if (tv[i].chk_w) begin
        chk($sformatf("vec%0d out_word", i), out_word, tv[i].e_w);
        chk($sformatf("vec%0d out_word_msb", i), out_word1, rev8(tv[i].e_w));
      end
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back streaming with out_ready held high: no bubbles, one-cycle pulses.
    b2b[0] = 8'hA5;
    b2b[1] = 8'h3C;
    stream = {b2b[1], b2b[0]};
    for (int k = 0; k <= 16; k++) begin
      drive(1'b0, 1'b0, (k < 16) ? 1'b1 : 1'b0, (k < 16) ? stream[k] : 1'b0, 1'b1);
      #1;
      if (k < 16) chk($sformatf("b2b%0d in_ready", k), {7'd0, in_ready}, 8'd1);
      chk($sformatf("b2b%0d out_valid", k), {7'd0, out_valid},
          {7'd0, (k == 8 || k == 16)});
      if (k == 8 || k == 16) begin
        chk($sformatf("b2b%0d out_word", k), out_word, b2b[k/8 - 1]);
        chk($sformatf("b2b%0d out_word_msb", k), out_word1, rev8(b2b[k/8 - 1]));
      end
      if (k == 9) chk("b2b9 bit_index", {5'd0, bit_index}, 8'd1);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_state("b2b_end", 1'b1, 1'b0, 8'h3C, 3'd0);

    // Backpressure: held byte blocks input until the consumer takes it.
    send_byte(8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_state($sformatf("bp%0d", i), 1'b0, 1'b1, 8'hFF, 3'd0);
      step();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_state("bp_xfer", 1'b1, 1'b1, 8'hFF, 3'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("bp_after out_valid", {7'd0, out_valid}, 8'd0);
    chk("bp_after bit_index", {5'd0, bit_index}, 8'd1);
    for (int i = 1; i < 8; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_state("bp_next", 1'b0, 1'b1, 8'h01, 3'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while holding a byte, then a clean byte afterwards.
    send_byte(8'h77, 1'b0);
    check_state("hold77", 1'b0, 1'b1, 8'h77, 3'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_state("rst_hold", 1'b1, 1'b0, 8'h00, 3'd0);
    send_byte(8'h5A, 1'b0);
    check_state("post_rst", 1'b0, 1'b1, 8'h5A, 3'd0);

    // Flush in HOLD with coincident transfer and accept: byte leaves, bit is dropped.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_state("hold_flush", 1'b1, 1'b0, 8'h5A, 3'd0);
    send_byte(8'h00, 1'b0);
    check_state("hold_flush_next", 1'b0, 1'b1, 8'h00, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
